// File: rtl/alu_sched_16b.sv
// Micro-op issue sequencer for the 16-bit ALU/AGU datapath: reg/imm, load-op and RMW sequencing.
// Optional perf counters (perf_retired, perf_stall) are enabled by defining ALU_SCHED_PERF_EN.
module alu_sched_16b #(
    parameter int unsigned RF_AW = 3,
    parameter int unsigned IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             uop_valid,
    output logic             uop_ready,
    input  logic [3:0]       uop_op,
    input  logic [1:0]       uop_mode,
    input  logic             uop_cin,
    input  logic             uop_sf_we,
    input  logic [RF_AW-1:0] uop_rd,
    input  logic [RF_AW-1:0] uop_ra,
    input  logic [RF_AW-1:0] uop_rb,
    input  logic [IMM_W-1:0] uop_imm,
    input  logic             sched_flush,
    output logic [3:0]       alu_f,
    output logic             carry_mask,
    output logic [IMM_W-1:0] sched_t16,
    output logic             sched_bypass_b,
    output logic [RF_AW-1:0] rf_ra_sel,
    output logic [RF_AW-1:0] rf_rb_sel,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_wsel,
    output logic             rf_sf_we,
    output logic             lsu_req,
    output logic             lsu_we,
    output logic             lsu_reuse_adr,
    input  logic             lsu_ack,
    input  logic [IMM_W-1:0] lsu_rdata,
`ifdef ALU_SCHED_PERF_EN
    output logic [15:0]      perf_retired,
    output logic [15:0]      perf_stall,
`endif
    output logic             sched_busy
);

    typedef enum logic [2:0] {StIdle, StExec, StAddr, StLdwait, StStore} state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q;
    logic [1:0]         mode_q;
    logic               cin_q;
    logic               sf_we_q;
    logic [RF_AW-1:0]   rd_q, ra_q, rb_q;
    logic [IMM_W-1:0]   imm_q;
    logic [IMM_W-1:0]   data_q;
    logic               abort_q, abort_d;
    logic               accept;
    logic               in_mem;

    assign accept = uop_valid & uop_ready;
    assign in_mem = (state_q == StLdwait) || (state_q == StStore);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            mode_q  <= '0;
            cin_q   <= 1'b0;
            sf_we_q <= 1'b0;
            rd_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            imm_q   <= '0;
            data_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
            if (accept) begin
                op_q    <= uop_op;
                mode_q  <= uop_mode;
                cin_q   <= uop_cin;
                sf_we_q <= uop_sf_we;
                rd_q    <= uop_rd;
                ra_q    <= uop_ra;
                rb_q    <= uop_rb;
                imm_q   <= uop_imm;
            end
            if (state_q == StLdwait && lsu_ack) begin
                data_q <= lsu_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        abort_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = uop_mode[1] ? StAddr : StExec;
            end
            StExec: begin
                if (sched_flush)         state_d = StIdle;
                else if (mode_q == 2'b11) state_d = StStore;
                else if (accept)          state_d = uop_mode[1] ? StAddr : StExec;
                else                      state_d = StIdle;
            end
            StAddr: begin
                state_d = sched_flush ? StIdle : StLdwait;
            end
            StLdwait: begin
                // A flush here cannot withdraw the request; it only drops the writeback.
                abort_d = (abort_q | sched_flush) & ~lsu_ack;
                if (lsu_ack) state_d = (abort_q | sched_flush) ? StIdle : StExec;
            end
            StStore: begin
                abort_d = (abort_q | sched_flush) & ~lsu_ack;
                if (lsu_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        uop_ready      = 1'b0;
        alu_f          = '0;
        carry_mask     = 1'b0;
        sched_t16      = '0;
        sched_bypass_b = 1'b0;
        rf_ra_sel      = '0;
        rf_rb_sel      = '0;
        rf_we          = 1'b0;
        rf_wsel        = '0;
        rf_sf_we       = 1'b0;
        lsu_req        = 1'b0;
        lsu_we         = 1'b0;
        lsu_reuse_adr  = 1'b0;
        sched_busy     = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                uop_ready = rst_n;
            end
            StExec, StStore: begin
                alu_f          = op_q;
                carry_mask     = cin_q;
                rf_ra_sel      = ra_q;
                rf_rb_sel      = rb_q;
                sched_bypass_b = (mode_q != 2'b00);
                sched_t16      = mode_q[1] ? data_q : imm_q;
                if (state_q == StExec) begin
                    uop_ready = (mode_q != 2'b11) & ~sched_flush;
                    rf_we     = (mode_q != 2'b11) & ~sched_flush;
                    rf_wsel   = rd_q;
                    rf_sf_we  = sf_we_q & ~sched_flush;
                end else begin
                    lsu_req       = 1'b1;
                    lsu_we        = 1'b1;
                    lsu_reuse_adr = 1'b1;
                end
            end
            StAddr, StLdwait: begin
                // AGU forms rf_a + imm for the load address.
                alu_f          = op_q;
                rf_ra_sel      = ra_q;
                sched_t16      = imm_q;
                sched_bypass_b = 1'b1;
                lsu_req        = (state_q == StLdwait) | ~sched_flush;
            end
            default: ;
        endcase
    end

`ifdef ALU_SCHED_PERF_EN
    logic retire;
    logic stall;

    assign retire = (state_q == StExec && mode_q != 2'b11 && !sched_flush) ||
                    (state_q == StStore && lsu_ack && !abort_q && !sched_flush);
    assign stall  = in_mem & ~lsu_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired <= '0;
            perf_stall   <= '0;
        end else begin
            if (retire) perf_retired <= perf_retired + 16'd1;
            if (stall)  perf_stall   <= perf_stall + 16'd1;
        end
    end
`else
    logic unused_in_mem;
    assign unused_in_mem = in_mem;
`endif

endmodule

// File: tb/tb_alu_sched_16b.sv
// Self-checking bench for alu_sched_16b; writeback/flag events are scoreboarded through a queue.
module tb_alu_sched_16b;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uop_valid = 1'b0;
    logic        uop_ready;
    logic [3:0]  uop_op = '0;
    logic [1:0]  uop_mode = '0;
    logic        uop_cin = 1'b0;
    logic        uop_sf_we = 1'b0;
    logic [2:0]  uop_rd = '0, uop_ra = '0, uop_rb = '0;
    logic [15:0] uop_imm = '0;
    logic        sched_flush = 1'b0;
    logic [3:0]  alu_f;
    logic        carry_mask;
    logic [15:0] sched_t16;
    logic        sched_bypass_b;
    logic [2:0]  rf_ra_sel, rf_rb_sel, rf_wsel;
    logic        rf_we, rf_sf_we;
    logic        lsu_req, lsu_we, lsu_reuse_adr;
    logic        lsu_ack = 1'b0;
    logic [15:0] lsu_rdata = '0;
    logic        sched_busy;
`ifdef ALU_SCHED_PERF_EN
    logic [15:0] perf_retired, perf_stall;
    logic [15:0] exp_retired = '0;
`endif

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        we;
        logic        sf;
        logic [2:0]  wsel;
        logic [3:0]  f;
        logic        cin;
        logic        byp;
        logic [15:0] t16;
    } wb_t;

    wb_t wb_q[$];
    wb_t mon_e;

    always #5 clk = ~clk;

    alu_sched_16b dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .uop_valid      (uop_valid),
        .uop_ready      (uop_ready),
        .uop_op         (uop_op),
        .uop_mode       (uop_mode),
        .uop_cin        (uop_cin),
        .uop_sf_we      (uop_sf_we),
        .uop_rd         (uop_rd),
        .uop_ra         (uop_ra),
        .uop_rb         (uop_rb),
        .uop_imm        (uop_imm),
        .sched_flush    (sched_flush),
        .alu_f          (alu_f),
        .carry_mask     (carry_mask),
        .sched_t16      (sched_t16),
        .sched_bypass_b (sched_bypass_b),
        .rf_ra_sel      (rf_ra_sel),
        .rf_rb_sel      (rf_rb_sel),
        .rf_we          (rf_we),
        .rf_wsel        (rf_wsel),
        .rf_sf_we       (rf_sf_we),
        .lsu_req        (lsu_req),
        .lsu_we         (lsu_we),
        .lsu_reuse_adr  (lsu_reuse_adr),
        .lsu_ack        (lsu_ack),
        .lsu_rdata      (lsu_rdata),
`ifdef ALU_SCHED_PERF_EN
        .perf_retired   (perf_retired),
        .perf_stall     (perf_stall),
`endif
        .sched_busy     (sched_busy)
    );

    function automatic wb_t mk_wb(input logic we, input logic sf, input logic [2:0] wsel,
                                  input logic [3:0] f, input logic cin, input logic byp,
                                  input logic [15:0] t16);
        wb_t e;
        e.we = we; e.sf = sf; e.wsel = wsel; e.f = f; e.cin = cin; e.byp = byp; e.t16 = t16;
        return e;
    endfunction

    task automatic set_uop(input logic v, input logic [3:0] op, input logic [1:0] mode,
                           input logic cin, input logic sf, input logic [2:0] rd,
                           input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] imm);
        uop_valid = v; uop_op = op; uop_mode = mode; uop_cin = cin; uop_sf_we = sf;
        uop_rd = rd; uop_ra = ra; uop_rb = rb; uop_imm = imm;
    endtask

    // Every register-file or flag write must match the oldest expected writeback.
    always @(negedge clk) begin
        if (rst_n && (rf_we || rf_sf_we)) begin
            n_checks++;
            if (wb_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: rf_we=%0b rf_sf_we=%0b wsel=%0d t16=%h, none expected",
                         rf_we, rf_sf_we, rf_wsel, sched_t16);
            end else begin
                mon_e = wb_q.pop_front();
                if (rf_we !== mon_e.we || rf_sf_we !== mon_e.sf ||
                    (mon_e.we && rf_wsel !== mon_e.wsel) || alu_f !== mon_e.f ||
                    carry_mask !== mon_e.cin || sched_bypass_b !== mon_e.byp ||
                    sched_t16 !== mon_e.t16) begin
                    n_fail++;
                    $display("FAIL wb_fields: got we=%0b sf=%0b wsel=%0d f=%h cin=%0b byp=%0b t16=%h, want we=%0b sf=%0b wsel=%0d f=%h cin=%0b byp=%0b t16=%h",
                             rf_we, rf_sf_we, rf_wsel, alu_f, carry_mask, sched_bypass_b,
                             sched_t16, mon_e.we, mon_e.sf, mon_e.wsel, mon_e.f, mon_e.cin,
                             mon_e.byp, mon_e.t16);
                end
            end
        end
    end

    task automatic test_reset();
        #2;
        n_checks++;
        if ({uop_ready, lsu_req, rf_we, rf_sf_we, sched_busy, alu_f, sched_t16} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%0b req=%0b we=%0b busy=%0b t16=%h, want all 0",
                     uop_ready, lsu_req, rf_we, sched_busy, sched_t16);
        end
        @(negedge clk); rst_n = 1'b1;
        #1;
        n_checks++;
        if (uop_ready !== 1'b1 || sched_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%0b busy=%0b, want 1/0", uop_ready, sched_busy);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        set_uop(1'b1, 4'h0, 2'b00, 1'b0, 1'b1, 3'd3, 3'd1, 3'd2, 16'h0);
        wb_q.push_back(mk_wb(1'b1, 1'b1, 3'd3, 4'h0, 1'b0, 1'b0, 16'h0));
        @(posedge clk); #1;
        set_uop(1'b1, 4'h1, 2'b01, 1'b0, 1'b0, 3'd4, 3'd1, 3'd0, 16'd5);
        wb_q.push_back(mk_wb(1'b1, 1'b0, 3'd4, 4'h1, 1'b0, 1'b1, 16'd5));
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b1 || uop_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: rf_we=%0b ready=%0b, want 1/1", rf_we, uop_ready);
        end
        @(posedge clk); #1;
        set_uop(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0);
        @(negedge clk);
        n_checks++;
        if (rf_we !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: rf_we=%0b, want 1", rf_we);
        end
        @(posedge clk); #1;
        n_checks++;
        if (sched_busy !== 1'b0 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%0b rf_we=%0b, want 0/0", sched_busy, rf_we);
        end
`ifdef ALU_SCHED_PERF_EN
        exp_retired += 16'd2;
`endif
    endtask

    task automatic test_exec_flush();
        @(posedge clk); #1;
        set_uop(1'b1, 4'h5, 2'b00, 1'b0, 1'b1, 3'd7, 3'd1, 3'd1, 16'h0);
        @(posedge clk); #1;
        sched_flush = 1'b1;
        set_uop(1'b1, 4'h6, 2'b01, 1'b0, 1'b1, 3'd2, 3'd1, 3'd1, 16'h9);
        @(negedge clk);
        n_checks++;
        if (uop_ready !== 1'b0 || rf_we !== 1'b0 || rf_sf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL exec_flush: ready=%0b rf_we=%0b sf_we=%0b, want 0/0/0",
                     uop_ready, rf_we, rf_sf_we);
        end
        @(posedge clk); #1;
        sched_flush = 1'b0;
        uop_valid = 1'b0;
        lsu_ack = 1'b1;
        n_checks++;
        if (sched_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL exec_flush_idle: busy=%0b, want 0", sched_busy);
        end
        @(posedge clk); #1;
        lsu_ack = 1'b0;
        n_checks++;
        if (sched_busy !== 1'b0 || lsu_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack_ignored: busy=%0b req=%0b, want 0/0", sched_busy, lsu_req);
        end
    endtask

    task automatic test_load_op();
        int req_cnt = 0;
`ifdef ALU_SCHED_PERF_EN
        logic [15:0] stall0 = perf_stall;
`endif
        @(posedge clk); #1;
        set_uop(1'b1, 4'h2, 2'b10, 1'b0, 1'b0, 3'd6, 3'd5, 3'd0, 16'h0010);
        wb_q.push_back(mk_wb(1'b1, 1'b0, 3'd6, 4'h2, 1'b0, 1'b1, 16'h00FF));
        @(posedge clk); #1;
        uop_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                lsu_ack = 1'b1;
                lsu_rdata = 16'h00FF;
            end
            @(negedge clk);
            if (lsu_req === 1'b1) req_cnt++;
            n_checks++;
            if (lsu_req !== 1'b1 || lsu_we !== 1'b0 || sched_t16 !== 16'h0010 ||
                rf_ra_sel !== 3'd5 || rf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL load_addr[%0d]: req=%0b we=%0b t16=%h ra=%0d rf_we=%0b, want 1/0/0010/5/0",
                         c, lsu_req, lsu_we, sched_t16, rf_ra_sel, rf_we);
            end
            @(posedge clk); #1;
            lsu_ack = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (lsu_req !== 1'b0 || rf_we !== 1'b1 || req_cnt != 4) begin
            n_fail++;
            $display("FAIL load_exec: req=%0b rf_we=%0b req_cycles=%0d, want 0/1/4",
                     lsu_req, rf_we, req_cnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if (sched_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_idle: busy=%0b, want 0", sched_busy);
        end
`ifdef ALU_SCHED_PERF_EN
        exp_retired += 16'd1;
        n_checks++;
        if (perf_stall - stall0 !== 16'd2) begin
            n_fail++;
            $display("FAIL load_stall: delta=%0d, want 2", perf_stall - stall0);
        end
`endif
    endtask

    task automatic test_rmw();
        @(posedge clk); #1;
        set_uop(1'b1, 4'h3, 2'b11, 1'b1, 1'b1, 3'd0, 3'd2, 3'd0, 16'h0020);
        wb_q.push_back(mk_wb(1'b0, 1'b1, 3'd0, 4'h3, 1'b1, 1'b1, 16'h7FFF));
        @(posedge clk); #1;
        uop_valid = 1'b0;
        @(posedge clk); #1;
        lsu_ack = 1'b1;
        lsu_rdata = 16'h7FFF;
        @(posedge clk); #1;
        lsu_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (lsu_req !== 1'b0 || uop_ready !== 1'b0 || rf_we !== 1'b0 || rf_sf_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rmw_exec: req=%0b ready=%0b rf_we=%0b sf_we=%0b, want 0/0/0/1",
                     lsu_req, uop_ready, rf_we, rf_sf_we);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (c == 1) lsu_ack = 1'b1;
            @(negedge clk);
            n_checks++;
            if (lsu_req !== 1'b1 || lsu_we !== 1'b1 || lsu_reuse_adr !== 1'b1 ||
                rf_we !== 1'b0 || rf_sf_we !== 1'b0 || sched_t16 !== 16'h7FFF ||
                alu_f !== 4'h3) begin
                n_fail++;
                $display("FAIL rmw_store[%0d]: req=%0b we=%0b reuse=%0b rf_we=%0b sf=%0b t16=%h f=%h",
                         c, lsu_req, lsu_we, lsu_reuse_adr, rf_we, rf_sf_we, sched_t16, alu_f);
            end
        end
        @(posedge clk); #1;
        lsu_ack = 1'b0;
        n_checks++;
        if (sched_busy !== 1'b0 || lsu_req !== 1'b0 || uop_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmw_idle: busy=%0b req=%0b ready=%0b, want 0/0/1",
                     sched_busy, lsu_req, uop_ready);
        end
`ifdef ALU_SCHED_PERF_EN
        exp_retired += 16'd1;
`endif
    endtask

    task automatic test_ldwait_flush();
        @(posedge clk); #1;
        set_uop(1'b1, 4'h2, 2'b10, 1'b0, 1'b1, 3'd1, 3'd4, 3'd0, 16'h0044);
        @(posedge clk); #1;
        uop_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sched_flush = (c == 1);
            if (c == 3) lsu_ack = 1'b1;
            @(negedge clk);
            n_checks++;
            if (lsu_req !== 1'b1 || rf_we !== 1'b0 || rf_sf_we !== 1'b0 ||
                sched_t16 !== 16'h0044) begin
                n_fail++;
                $display("FAIL flush_ldwait[%0d]: req=%0b rf_we=%0b sf=%0b t16=%h, want 1/0/0/0044",
                         c, lsu_req, rf_we, rf_sf_we, sched_t16);
            end
            @(posedge clk); #1;
            sched_flush = 1'b0;
            lsu_ack = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (sched_busy !== 1'b0 || lsu_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: busy=%0b req=%0b, want 0/0", sched_busy, lsu_req);
        end
`ifdef ALU_SCHED_PERF_EN
        n_checks++;
        if (perf_retired !== exp_retired) begin
            n_fail++;
            $display("FAIL flush_retired: got %h want %h", perf_retired, exp_retired);
        end
`endif
    endtask

    task automatic test_reset_in_store();
        @(posedge clk); #1;
        set_uop(1'b1, 4'h4, 2'b11, 1'b0, 1'b1, 3'd0, 3'd3, 3'd0, 16'h0030);
        wb_q.push_back(mk_wb(1'b0, 1'b1, 3'd0, 4'h4, 1'b0, 1'b1, 16'h1234));
        @(posedge clk); #1;
        uop_valid = 1'b0;
        @(posedge clk); #1;
        lsu_ack = 1'b1;
        lsu_rdata = 16'h1234;
        @(posedge clk); #1;
        lsu_ack = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (lsu_req !== 1'b1 || lsu_we !== 1'b1) begin
            n_fail++;
            $display("FAIL store_before_reset: req=%0b we=%0b, want 1/1", lsu_req, lsu_we);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({uop_ready, lsu_req, lsu_we, lsu_reuse_adr, rf_we, rf_sf_we, sched_busy,
             sched_bypass_b, sched_t16, alu_f} !== '0) begin
            n_fail++;
            $display("FAIL reset_in_store: ready=%0b req=%0b we=%0b busy=%0b t16=%h, want all 0",
                     uop_ready, lsu_req, lsu_we, sched_busy, sched_t16);
        end
        @(negedge clk); rst_n = 1'b1;
        #1;
        n_checks++;
        if (uop_ready !== 1'b1 || sched_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_store_release: ready=%0b busy=%0b, want 1/0",
                     uop_ready, sched_busy);
        end
`ifdef ALU_SCHED_PERF_EN
        exp_retired = '0;
        n_checks++;
        if (perf_retired !== 16'h0 || perf_stall !== 16'h0) begin
            n_fail++;
            $display("FAIL perf_reset: retired=%h stall=%h, want 0/0", perf_retired, perf_stall);
        end
`endif
    endtask

`ifdef ALU_SCHED_PERF_EN
    task automatic test_perf_wrap();
        @(posedge clk); #1;
        set_uop(1'b1, 4'h7, 2'b00, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 16'h0);
        wb_q.push_back(mk_wb(1'b1, 1'b0, 3'd1, 4'h7, 1'b0, 1'b0, 16'h0));
        for (int i = 1; i < 65535; i++) begin
            @(posedge clk); #1;
            wb_q.push_back(mk_wb(1'b1, 1'b0, 3'd1, 4'h7, 1'b0, 1'b0, 16'h0));
        end
        @(posedge clk); #1;
        uop_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (perf_retired !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL perf_full: got %h want ffff", perf_retired);
        end
        set_uop(1'b1, 4'h7, 2'b00, 1'b0, 1'b0, 3'd1, 3'd2, 3'd3, 16'h0);
        wb_q.push_back(mk_wb(1'b1, 1'b0, 3'd1, 4'h7, 1'b0, 1'b0, 16'h0));
        @(posedge clk); #1;
        uop_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (perf_retired !== 16'h0000) begin
            n_fail++;
            $display("FAIL perf_wrap: got %h want 0000", perf_retired);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_exec_flush();
        test_load_op();
        test_rmw();
        test_ldwait_flush();
`ifdef ALU_SCHED_PERF_EN
        n_checks++;
        if (perf_retired !== exp_retired) begin
            n_fail++;
            $display("FAIL perf_retired: got %h want %h", perf_retired, exp_retired);
        end
`endif
        test_reset_in_store();
`ifdef ALU_SCHED_PERF_EN
        test_perf_wrap();
`endif
        @(posedge clk); #1;
        n_checks++;
        if (wb_q.size() != 0) begin
            n_fail++;
            $display("FAIL wb_missing: %0d expected writebacks never seen, want 0", wb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
